// File: rtl/ram_port_arbiter_if.sv
// Client-side request/acknowledge bundle for the RAM port arbiter.
// Two clients (req/we/addr/wdata in, ack out) plus shared rdata and busy.
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  ack0;
    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, ack1, rdata, busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, ack1, rdata, busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin two-client arbiter and sequencer for a single RAM bus.
// Ports: clk, rst (async high), bus (client bundle), ram_addr/ram_data/
// ram_cs/ram_we/ram_oe (RAM pins; ram_data driven only during a write).
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_arbiter_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LATENCY - 1);

    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_last;
    logic                  r_sel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_drive;
    logic                  r_cs;
    logic                  r_we;
    logic                  r_oe;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_busy;

    logic                  w_g0;
    logic                  w_g1;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // On a tie the client that did not win last time gets the bus;
    // r_last holds the index of the previous winner.
    assign w_g0    = bus.req0 & (~bus.req1 | r_last);
    assign w_g1    = bus.req1 & (~bus.req0 | ~r_last);
    assign w_we    = w_g1 ? bus.we1    : bus.we0;
    assign w_addr  = w_g1 ? bus.addr1  : bus.addr0;
    assign w_wdata = w_g1 ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_drive <= 1'b0;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_oe    <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_g0 | w_g1) begin
                        r_sel  <= w_g1;
                        r_last <= w_g1;
                        r_addr <= w_addr;
                        r_busy <= 1'b1;
                        r_cs   <= 1'b1;
                        if (w_we) begin
                            // Write acks in the same cycle the strobe is on.
                            r_state <= S_WR;
                            r_we    <= 1'b1;
                            r_drive <= 1'b1;
                            r_wdata <= w_wdata;
                            r_ack0  <= ~w_g1;
                            r_ack1  <= w_g1;
                        end else begin
                            r_state <= S_RD;
                            r_oe    <= 1'b1;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_WR: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b0;
                    r_we    <= 1'b0;
                    r_drive <= 1'b0;
                    r_busy  <= 1'b0;
                end
                S_RD: begin
                    if (r_cnt == '0) begin
                        r_rdata <= ram_data;
                        r_state <= S_RESP;
                        r_cs    <= 1'b0;
                        r_oe    <= 1'b0;
                        r_ack0  <= ~r_sel;
                        r_ack1  <= r_sel;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ram_addr = r_addr;
    assign ram_cs   = r_cs;
    assign ram_we   = r_we;
    assign ram_oe   = r_oe;
    assign ram_data = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

    assign bus.ack0  = r_ack0;
    assign bus.ack1  = r_ack1;
    assign bus.rdata = r_rdata;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: instance A (RD_LATENCY=1) checked every cycle
// against a transaction-schedule model; instance B (RD_LATENCY=3) directed.
module tb_ram_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk;
    logic rst;
    logic rst_b;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if ifa ();
    ram_port_arbiter_if ifb ();

    logic        t_req  [2][2];
    logic        t_we   [2][2];
    logic [11:0] t_addr [2][2];
    logic [15:0] t_wd   [2][2];

    assign ifa.req0   = t_req[0][0];
    assign ifa.we0    = t_we[0][0];
    assign ifa.addr0  = t_addr[0][0];
    assign ifa.wdata0 = t_wd[0][0];
    assign ifa.req1   = t_req[0][1];
    assign ifa.we1    = t_we[0][1];
    assign ifa.addr1  = t_addr[0][1];
    assign ifa.wdata1 = t_wd[0][1];
    assign ifb.req0   = t_req[1][0];
    assign ifb.we0    = t_we[1][0];
    assign ifb.addr0  = t_addr[1][0];
    assign ifb.wdata0 = t_wd[1][0];
    assign ifb.req1   = t_req[1][1];
    assign ifb.we1    = t_we[1][1];
    assign ifb.addr1  = t_addr[1][1];
    assign ifb.wdata1 = t_wd[1][1];

    logic [11:0] a_addr, b_addr;
    wire  [15:0] a_data, b_data;
    logic        a_cs, a_we, a_oe;
    logic        b_cs, b_we, b_oe;

    ram_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .RD_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa),
        .ram_addr(a_addr), .ram_data(a_data),
        .ram_cs(a_cs), .ram_we(a_we), .ram_oe(a_oe)
    );

    ram_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .RD_LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb),
        .ram_addr(b_addr), .ram_data(b_data),
        .ram_cs(b_cs), .ram_we(b_we), .ram_oe(b_oe)
    );

    // Simple RAM devices: asynchronous read while cs&oe, write on clock edge.
    logic [15:0] mem_a [4096];
    logic [15:0] mem_b [4096];
    assign a_data = (a_cs && a_oe && !a_we) ? mem_a[a_addr] : 16'hzzzz;
    assign b_data = (b_cs && b_oe && !b_we) ? mem_b[b_addr] : 16'hzzzz;
    always @(posedge clk) if (a_cs && a_we) mem_a[a_addr] <= a_data;
    always @(posedge clk) if (b_cs && b_we) mem_b[b_addr] <= b_data;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic ack_of(input int inst, input int c);
        if (inst == 0) return (c == 0) ? ifa.ack0 : ifa.ack1;
        return (c == 0) ? ifb.ack0 : ifb.ack1;
    endfunction

    function automatic logic [15:0] rdata_of(input int inst);
        return (inst == 0) ? ifa.rdata : ifb.rdata;
    endfunction

    // Model: expected bus/ack contents per cycle, as a queue of cycle records.
    typedef struct packed {
        logic        idle;
        logic        cs;
        logic        we;
        logic        oe;
        logic [11:0] addr;
        logic [15:0] wd;
        logic        ack0;
        logic        ack1;
        logic        rv;
        logic [15:0] rdata;
    } exp_t;

    exp_t        mq[$];
    exp_t        cur;
    logic        m_last;
    logic [15:0] mmem [int];

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.idle = 1'b1;
        return e;
    endfunction

    function automatic logic [15:0] mget(input int a);
        return mmem.exists(a) ? mmem[a] : 16'h0;
    endfunction

    initial begin
        int   w;
        logic go;
        logic wr;
        int   a;
        exp_t e;
        cur    = idle_e();
        m_last = 1'b1;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                cur    = idle_e();
                m_last = 1'b1;
            end else begin
                if (cur.idle && mq.size() == 0) begin
                    go = 1'b1;
                    w  = 0;
                    if (ifa.req0 && ifa.req1) w = m_last ? 0 : 1;
                    else if (ifa.req0)        w = 0;
                    else if (ifa.req1)        w = 1;
                    else                      go = 1'b0;
                    if (go) begin
                        m_last = (w == 1);
                        wr = (w == 1) ? ifa.we1 : ifa.we0;
                        a  = int'((w == 1) ? ifa.addr1 : ifa.addr0);
                        e  = '0;
                        e.cs   = 1'b1;
                        e.addr = 12'(a);
                        if (wr) begin
                            e.we   = 1'b1;
                            e.wd   = (w == 1) ? ifa.wdata1 : ifa.wdata0;
                            e.ack0 = (w == 0);
                            e.ack1 = (w == 1);
                            mq.push_back(e);
                            mmem[a] = e.wd;
                        end else begin
                            e.oe = 1'b1;
                            for (int i = 0; i < LAT_A; i++) mq.push_back(e);
                            e       = '0;
                            e.ack0  = (w == 0);
                            e.ack1  = (w == 1);
                            e.rv    = 1'b1;
                            e.rdata = mget(a);
                            mq.push_back(e);
                        end
                    end
                end
                cur = (mq.size() > 0) ? mq.pop_front() : idle_e();
            end
        end
    end

    // Per-cycle comparison of instance A, bus-safety of both instances.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("a_cs", a_cs, cur.cs);
                chk("a_we", a_we, cur.we);
                chk("a_oe", a_oe, cur.oe);
                chk("a_busy", ifa.busy, !cur.idle);
                chk("a_ack0", ifa.ack0, cur.ack0);
                chk("a_ack1", ifa.ack1, cur.ack1);
                if (cur.cs) chk("a_addr", a_addr, cur.addr);
                if (cur.we) chk("a_wdata_bus", a_data, cur.wd);
                if (cur.rv) chk("a_rdata", ifa.rdata, cur.rdata);
                chk("a_we_oe_excl", a_we & a_oe, 0);
                chk("a_ack_excl", ifa.ack0 & ifa.ack1, 0);
            end
            if (!rst_b) begin
                chk("b_we_oe_excl", b_we & b_oe, 0);
                chk("b_ack_excl", ifb.ack0 & ifb.ack1, 0);
            end
        end
    end

    logic        s_cs, s_we, s_oe, s_busy;
    logic [11:0] s_addr;
    logic [15:0] s_data;

    // Caller is at posedge+2; returns at posedge+2 after the drop of req.
    task automatic txn(input int inst, input int c, input logic w,
                       input logic [11:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        t_we[inst][c]   = w;
        t_addr[inst][c] = a;
        t_wd[inst][c]   = d;
        t_req[inst][c]  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (ack_of(inst, c)) begin
                got = 1'b1;
                rd  = rdata_of(inst);
                if (inst == 0) begin
                    s_cs   = a_cs;
                    s_we   = a_we;
                    s_oe   = a_oe;
                    s_busy = ifa.busy;
                    s_addr = a_addr;
                    s_data = a_data;
                end
            end
        end
        chk("ack_seen", got, 1);
        @(posedge clk);
        #2;
        t_req[inst][c] = 1'b0;
    endtask

    logic [15:0] rd;
    int          lat;
    int          order[$];
    int          first;
    logic        d0, d1, s0, s1;
    logic [11:0] qaddr [4];
    logic [15:0] qdata [4];

    initial begin
        rst   = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                t_req[i][j]  = 1'b0;
                t_we[i][j]   = 1'b0;
                t_addr[i][j] = '0;
                t_wd[i][j]   = '0;
            end
        qaddr[0] = 12'h000; qdata[0] = 16'h1111;
        qaddr[1] = 12'h400; qdata[1] = 16'h2222;
        qaddr[2] = 12'h800; qdata[2] = 16'h3333;
        qaddr[3] = 12'hC00; qdata[3] = 16'h4444;

        @(negedge clk);
        @(negedge clk);
        chk("rst_cs", a_cs, 0);
        chk("rst_we", a_we, 0);
        chk("rst_oe", a_oe, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_ack", {ifa.ack0, ifa.ack1}, 0);
        chk("rst_rdata", ifa.rdata, 0);

        // Contention straight after reset: both write, held continuously.
        @(posedge clk);
        #2;
        rst = 1'b0;
        rst_b = 1'b0;
        t_we[0][0] = 1'b1; t_addr[0][0] = 12'h200; t_wd[0][0] = 16'hAAAA;
        t_we[0][1] = 1'b1; t_addr[0][1] = 12'h201; t_wd[0][1] = 16'h5555;
        t_req[0][0] = 1'b1;
        t_req[0][1] = 1'b1;
        for (int i = 0; i < 30 && order.size() < 4; i++) begin
            @(negedge clk);
            if (ifa.ack0) order.push_back(0);
            if (ifa.ack1) order.push_back(1);
        end
        @(posedge clk);
        #2;
        t_req[0][0] = 1'b0;
        t_req[0][1] = 1'b0;
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("rr_order", (i < order.size()) ? order[i] : 9, i % 2);

        // Single write, client 0.
        txn(0, 0, 1'b1, 12'h123, 16'hBEEF, rd, lat);
        chk("wr_lat", lat, 2);
        chk("wr_cs", s_cs, 1);
        chk("wr_we", s_we, 1);
        chk("wr_oe", s_oe, 0);
        chk("wr_busy", s_busy, 1);
        chk("wr_addr", s_addr, 12'h123);
        chk("wr_data", s_data, 16'hBEEF);
        @(negedge clk);
        chk("wr_ack_1cyc", ifa.ack0, 0);
        chk("wr_busy_1cyc", ifa.busy, 0);
        @(posedge clk);
        #2;

        // Read back, client 1, latency 1.
        txn(0, 1, 1'b0, 12'h123, 16'h0, rd, lat);
        chk("rd1_data", rd, 16'hBEEF);
        chk("rd1_lat", lat, 3);

        // Latency 3 instance.
        txn(1, 0, 1'b1, 12'h123, 16'hBEEF, rd, lat);
        txn(1, 1, 1'b0, 12'h123, 16'h0, rd, lat);
        chk("rd3_data", rd, 16'hBEEF);
        chk("rd3_lat", lat, 5);

        // Quadrant pass-through.
        for (int i = 0; i < 4; i++)
            txn(0, i % 2, 1'b1, qaddr[i], qdata[i], rd, lat);
        for (int i = 0; i < 4; i++) begin
            txn(0, (i + 1) % 2, 1'b0, qaddr[i], 16'h0, rd, lat);
            chk("quad_rd", rd, qdata[i]);
        end

        // Fields changed after grant are ignored.
        txn(0, 0, 1'b1, 12'h010, 16'hA5A5, rd, lat);
        txn(0, 0, 1'b1, 12'h0FF, 16'h5A5A, rd, lat);
        t_we[0][0]   = 1'b0;
        t_addr[0][0] = 12'h010;
        t_req[0][0]  = 1'b1;
        @(posedge clk);
        #2;
        t_addr[0][0] = 12'h0FF;
        @(negedge clk);
        chk("latch_addr", a_addr, 12'h010);
        lat = 0;
        while (!ifa.ack0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latch_rdata", ifa.rdata, 16'hA5A5);
        @(posedge clk);
        #2;
        t_req[0][0] = 1'b0;

        // Reset during the second read cycle of instance B.
        t_we[1][1]   = 1'b0;
        t_addr[1][1] = 12'h123;
        t_req[1][1]  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("b_in_rd", b_cs & b_oe, 1);
        #1;
        rst_b = 1'b1;
        t_req[1][1] = 1'b0;
        #1;
        chk("b_rst_cs", b_cs, 0);
        chk("b_rst_oe", b_oe, 0);
        chk("b_rst_busy", ifb.busy, 0);
        chk("b_rst_rdata", ifb.rdata, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_rst_noack", {ifb.ack0, ifb.ack1}, 0);
        end
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        @(negedge clk);
        chk("b_post_noack", {ifb.ack0, ifb.ack1}, 0);
        @(posedge clk);
        #2;
        t_we[1][0]   = 1'b0;
        t_addr[1][0] = 12'h123;
        t_req[1][0]  = 1'b1;
        t_req[1][1]  = 1'b1;
        first = -1;
        d0 = 1'b0;
        d1 = 1'b0;
        for (int i = 0; i < 30 && !(d0 && d1); i++) begin
            @(negedge clk);
            s0 = ifb.ack0;
            s1 = ifb.ack1;
            if (first < 0 && (s0 || s1)) first = s0 ? 0 : 1;
            @(posedge clk);
            #2;
            if (s0) begin t_req[1][0] = 1'b0; d0 = 1'b1; end
            if (s1) begin t_req[1][1] = 1'b0; d1 = 1'b1; end
        end
        chk("b_first_grant", first, 0);
        chk("b_both_done", {d0, d1}, 2'b11);
        chk("b_rdata_after", ifb.rdata, 16'hBEEF);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and bus sequencer for the banked 4-quadrant RAM array (ADDR_WIDTH address, DATA_WIDTH bidirectional data, chip_select/write_enable/output_enable).
- Accepts independent read/write requests from two clients, e.g. instruction fetch and load/store unit, and serialises them onto the single RAM bus.
- Owns the tristate data bus and generates all RAM control strobes.
- Returns read data with a one-cycle acknowledge pulse.

Parameters:
- ADDR_WIDTH, 12, RAM word address width; top 2 bits select the quadrant inside the RAM.
- DATA_WIDTH, 16, RAM word width.
- RD_LATENCY, 1, cycles chip_select/output_enable are held before read data is sampled; legal range 1..4.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  client 0 request, held until ack0
- we0  in  1  client 0 write (1) / read (0)
- addr0  in  ADDR_WIDTH  client 0 address
- wdata0  in  DATA_WIDTH  client 0 write data
- ack0  out  1  client 0 completion pulse, 1 cycle
- req1, we1, addr1, wdata1, ack1: same as client 0, for client 1
- rdata  out  DATA_WIDTH  read data; valid only in the cycle ackN is high after a read
- busy  out  1  high whenever state != IDLE
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_data  inout  DATA_WIDTH  RAM data bus; driven only in WR, else high-Z
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable

Behaviour:
- All outputs registered. Reset (async, immediate) values:
  - state=IDLE
  - ram_cs=ram_we=ram_oe=0, ram_addr=0, ram_data=Z
  - ack0=ack1=0, rdata=0, busy=0
  - last_grant=1, so client 0 wins the first tie
- FSM states: IDLE, WR, RD, RESP.
- IDLE:
  - If exactly one reqN is high, grant it.
  - If both are high, grant the client != last_grant.
  - On grant: latch addr/we/wdata of the winner into internal regs, update last_grant, go to WR (we=1) or RD (we=0).
  - If neither request is high, stay in IDLE.
- WR, exactly 1 cycle:
  - ram_cs=1, ram_we=1, ram_oe=0, ram_addr=latched addr, ram_data driven with latched wdata.
  - ackN=1 for the granted client in this same cycle.
  - Next state: IDLE.
- RD, RD_LATENCY cycles:
  - ram_cs=1, ram_oe=1, ram_we=0, ram_addr=latched addr, ram_data=Z.
  - Down-counter loaded with RD_LATENCY-1 on entry.
  - On the edge leaving the final RD cycle, rdata <= ram_data, then go to RESP.
- RESP, 1 cycle:
  - ram_cs/ram_oe/ram_we=0, ram_data=Z.
  - ackN=1 for the granted client, rdata holds the captured word.
  - Next state: IDLE.
- rdata holds its value until the next read capture.
- Latency from grant:
  - write: ack in the 1st cycle after IDLE; 2 cycles per write.
  - read: ack in cycle RD_LATENCY+1 after IDLE; RD_LATENCY+2 cycles per read.
- Handshake:
  - A requester keeps reqN and its fields stable until it samples ackN=1, then deasserts reqN on that same edge.
  - Field changes after grant are ignored; latched values are used.
  - reqN still high in the IDLE cycle after its ack is a new request.
  - Dropping reqN after grant does not abort; the transaction completes and ackN still pulses.
- Arbitration:
  - Strict alternation under continuous contention; no client waits more than one transaction.
  - A lone requester is granted back-to-back regardless of last_grant.
- Bus safety:
  - ram_data is never driven while ram_oe=1.
  - ram_we and ram_oe are never high together.
  - At most one ackN is high in any cycle.
- Reset mid-operation: all outputs return to reset values asynchronously, the bus goes high-Z, the in-flight transaction is dropped with no ack, and last_grant=1.

Test Plan:
- Write, client 0, addr0=0x123, wdata0=0xBEEF -> next cycle ram_cs=1, ram_we=1, ram_oe=0, ram_addr=0x123, ram_data=0xBEEF, ack0=1 for exactly 1 cycle, busy=1 for 1 cycle.
- Read, client 1, addr1=0x123, RD_LATENCY=1 -> 1 cycle ram_cs=ram_oe=1 with ram_data=Z from the arbiter, then ack1=1 with rdata=0xBEEF; repeat with RD_LATENCY=3 -> ack1 in the 4th cycle after IDLE.
- req0 and req1 rise together right after reset, both held and re-asserted continuously -> grant order 0,1,0,1; ack0/ack1 never overlap.
- Writes 0x1111/0x2222/0x3333/0x4444 to 0x000/0x400/0x800/0xC00, then reads of the same addresses -> rdata returns each value; confirms quadrant addressing passes through unmodified.
- Change addr0 to 0x0FF in the cycle after grant of a read at 0x010 -> ram_addr stays 0x010 and the returned data matches 0x010.
- Assert rst during the 2nd RD cycle (RD_LATENCY=3) -> same-cycle ram_cs/ram_oe=0, ram_data=Z, no ack; after release with both reqs high, client 0 is granted first.
